// File: rtl/me_pkg.sv
// Shared motion-estimation constants: pixel/block geometry, candidate count and SAD width.
// Also consumed by the minimum-compare tree so both sides agree on sad_data packing.
package me_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned BLK   = 8;
    localparam int unsigned CAND  = 16;
    localparam int unsigned SAD_W = 14;
    localparam int unsigned REF_W = (BLK + CAND - 1) * PIX_W;

    // Smallest SAD width that holds a full block of worst-case differences.
    function automatic int unsigned sad_w_min(input int unsigned blk, input int unsigned pix_w);
        return $clog2(blk * blk * ((1 << pix_w) - 1) + 1);
    endfunction

endpackage

// File: rtl/sad_row_pe.sv
// Row term for one candidate: sum over BLK pixel pairs of |cur - ref|.
// Purely combinational; the top instantiates one per candidate offset.
module sad_row_pe #(
    parameter int unsigned PIX_W = me_pkg::PIX_W,
    parameter int unsigned BLK   = me_pkg::BLK
) (
    input  logic [BLK*PIX_W-1:0]            cur_row,
    input  logic [BLK*PIX_W-1:0]            ref_seg,
    output logic [PIX_W+$clog2(BLK)-1:0]    term
);

    localparam int unsigned TERM_W = PIX_W + $clog2(BLK);

    logic [PIX_W:0]   diff [BLK];
    logic [PIX_W-1:0] mag  [BLK];

    always_comb begin
        term = '0;
        for (int unsigned i = 0; i < BLK; i++) begin
            // One extra bit keeps the borrow, which selects the negated magnitude.
            diff[i] = {1'b0, cur_row[i*PIX_W +: PIX_W]} - {1'b0, ref_seg[i*PIX_W +: PIX_W]};
            mag[i]  = diff[i][PIX_W] ? PIX_W'(-diff[i]) : diff[i][PIX_W-1:0];
            term    = term + TERM_W'(mag[i]);
        end
    end

endmodule

// File: rtl/sad_row_accum.sv
// Row-serial SAD accumulator: sums CAND candidate row terms over BLK rows and hands the
// finished SADs to the compare tree through a valid/ready register that overlaps the next block.
module sad_row_accum #(
    parameter int unsigned PIX_W = me_pkg::PIX_W,
    parameter int unsigned BLK   = me_pkg::BLK,
    parameter int unsigned CAND  = me_pkg::CAND,
    parameter int unsigned SAD_W = me_pkg::SAD_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BLK*PIX_W-1:0]          cur_row,
    input  logic [(BLK+CAND-1)*PIX_W-1:0] ref_row,
    input  logic                          blk_abort,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CAND*SAD_W-1:0]         sad_data
);

    localparam int unsigned TERM_W = PIX_W + $clog2(BLK);
    localparam int unsigned CNT_W  = (BLK > 1) ? $clog2(BLK) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(BLK - 1);

    logic [TERM_W-1:0]     term [CAND];
    logic [SAD_W-1:0]      acc_q [CAND];
    logic [SAD_W-1:0]      acc_d [CAND];
    logic [CNT_W-1:0]      row_cnt_q, row_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [CAND*SAD_W-1:0] sad_q, sad_d;
    logic                  final_row;
    logic                  accept;

    for (genvar k = 0; k < CAND; k++) begin : g_pe
        sad_row_pe #(
            .PIX_W (PIX_W),
            .BLK   (BLK)
        ) u_pe (
            .cur_row (cur_row),
            .ref_seg (ref_row[k*PIX_W +: BLK*PIX_W]),
            .term    (term[k])
        );
    end

    assign final_row = (row_cnt_q == LAST_ROW);
    // Only the final row can stall, and only while the previous result is still unread.
    assign in_ready  = !(final_row && out_valid_q && !out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign sad_data  = sad_q;

    always_comb begin
        acc_d       = acc_q;
        row_cnt_d   = row_cnt_q;
        out_valid_d = out_valid_q;
        sad_d       = sad_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (blk_abort) begin
            for (int unsigned k = 0; k < CAND; k++) acc_d[k] = '0;
            row_cnt_d = '0;
        end else if (accept) begin
            if (final_row) begin
                for (int unsigned k = 0; k < CAND; k++) begin
                    sad_d[k*SAD_W +: SAD_W] = acc_q[k] + SAD_W'(term[k]);
                    acc_d[k]                = '0;
                end
                out_valid_d = 1'b1;
                row_cnt_d   = '0;
            end else begin
                for (int unsigned k = 0; k < CAND; k++) begin
                    acc_d[k] = acc_q[k] + SAD_W'(term[k]);
                end
                row_cnt_d = row_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < CAND; k++) acc_q[k] <= '0;
            row_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            sad_q       <= '0;
        end else begin
            acc_q       <= acc_d;
            row_cnt_q   <= row_cnt_d;
            out_valid_q <= out_valid_d;
            sad_q       <= sad_d;
        end
    end

endmodule

// File: doc/sad_row_accum.md
# sad_row_accum

Row-serial SAD accumulator that produces the 16 candidate SADs consumed by the motion-estimation minimum-compare tree. Each accepted beat carries one 8-pixel row of the current block plus the matching 23-pixel reference row. The block accumulates, for each of 16 horizontal candidate offsets, the sum of absolute differences over 8 rows. It then presents the 16 finished 14-bit SADs to the compare tree through a valid/ready output register. The output register is double-buffered against the accumulators, so the next block can stream in while the compare tree drains the previous one.

## Interface
- PIX_W, 8, pixel width
- BLK, 8, block width and height; rows per block
- CAND, 16, horizontal candidate offsets (0..CAND-1)
- SAD_W, 14, SAD width; must be ≥ clog2(BLK*BLK*(2^PIX_W-1)+1), which is 14 for the defaults
- REF_W, derived, (BLK+CAND-1)*PIX_W = 184
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  row beat valid
- in_ready  out  1  row beat accepted when in_valid && in_ready
- cur_row  in  BLK*PIX_W  current-block pixel i at [i*PIX_W +: PIX_W]
- ref_row  in  REF_W  reference pixel j at [j*PIX_W +: PIX_W], j = 0..BLK+CAND-2
- blk_abort  in  1  synchronous discard of the partially accumulated block
- out_valid  out  1  sad_data holds a finished block
- out_ready  in  1  downstream (compare tree) consumed sad_data
- sad_data  out  CAND*SAD_W  SAD of candidate k at [k*SAD_W +: SAD_W]; k maps to compare-tree input sad_data_k

## Operation
- Candidate k row term is Σ_{i=0..BLK-1} |cur[i] − ref[i+k]|, evaluated unsigned. The subtraction is PIX_W+1 bits wide before the absolute value.
- Row term width is PIX_W+clog2(BLK) = 11. It is zero-extended to SAD_W before being added to acc[k].
- Because of the SAD_W constraint, the accumulator never overflows. No saturation logic is present.
- row_cnt counts 0..BLK-1 and advances by 1 on each accepted beat.
- Accepted beat with row_cnt < BLK-1: acc[k] ← acc[k] + term[k].
- Accepted beat with row_cnt = BLK-1 (final row):
  - sad_data[k] ← acc[k] + term[k].
  - out_valid ← 1.
  - acc ← 0 and row_cnt ← 0.
- out_valid clears on out_valid && out_ready, unless a final row is accepted in the same cycle. In that case the register reloads and out_valid stays 1.
- in_ready = !(row_cnt == BLK-1 && out_valid && !out_ready). This is a combinational path from out_ready to in_ready.
- Non-final rows are never stalled.
- blk_abort:
  - Sets acc ← 0 and row_cnt ← 0.
  - A row accepted in the same cycle is dropped. Abort wins.
  - The output register and out_valid are unaffected.
- Reset (async assert, sync release): acc = 0, row_cnt = 0, out_valid = 0, sad_data = 0. With reset released, in_ready is 1.
- Reset in the middle of a block discards all partial sums. Any pending output is lost.

## Timing
- Latency: sad_data and out_valid are valid in the cycle after the handshake of the final (BLK-th) row.
- Throughput: 1 row/cycle. A new block may start in the cycle after a final row, giving back-to-back blocks every BLK cycles with no bubble while out_ready stays high.
- sad_data is stable while out_valid && !out_ready.
- No combinational path from in_valid, cur_row or ref_row to any output. sad_data and out_valid are registered.

## Structure
- A shared package `me_pkg` holds PIX_W, BLK, CAND and SAD_W defaults, the derived REF_W, and a function `sad_w_min(blk, pix_w)`. The same package constants parameterize the compare tree.
- There is one sub-module, `sad_row_pe`: a combinational BLK-pixel absolute-difference adder tree returning the row term for a single candidate. It is instantiated CAND times with ref_row slice [k*PIX_W +: BLK*PIX_W].
- The top level holds the accumulators, row_cnt, the output register and the handshake logic.

## Test plan
- cur all 0x00, ref all 0xFF, 8 rows, out_ready=1 → out_valid one cycle after row 7; every SAD = 16320 (0x3FC0), which is maximum width with no wrap.
- cur pixel i = 10*i, ref pixel j = 10*(j−5) clipped at 0, 8 rows → SAD[5] = 0 and all other SAD[k] > 0.
- Two blocks back-to-back with out_ready=1 → in_ready held at 1 and out_valid pulses on cycles 8 and 16. The second block's SADs are not contaminated by the first.
- out_ready=0 while the second block streams → in_ready drops only when row_cnt = 7. Raising out_ready makes in_ready 1 combinationally, the row is accepted in that same cycle, and the new SADs appear in the next cycle.
- blk_abort asserted with row 4 of a block → next 8 rows of all-ones difference (|Δ|=1) give SAD = 64 for every candidate. A pending output stays intact.
- rst_n pulsed low mid-block with out_valid=1 → out_valid=0 and sad_data=0 immediately (async). The next full block produces correct SADs.
